// File: rtl/seq_cla_subtractor.sv
// rtl/seq_cla_subtractor.sv - multi-cycle subtractor, one CHUNK slice of a + ~b + 1 per clock
module seq_cla_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic             carry, borrow_reg, overflow_reg;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_slice, b_slice, sum;
  logic             carry_out;

  // One slice of a + ~b + carry; carry starts at 1 to complete the two's complement.
  always_comb begin
    a_slice = a_reg[int'(idx) * CHUNK +: CHUNK];
    b_slice = b_reg[int'(idx) * CHUNK +: CHUNK];
    {carry_out, sum} = {1'b0, a_slice} + {1'b0, ~b_slice} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      diff_reg     <= '0;
      carry        <= 1'b0;
      idx          <= '0;
      borrow_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= minuend;
            b_reg <= subtrahend;
            idx   <= '0;
            carry <= 1'b1;
          end
        end
        CALC: begin
          diff_reg[int'(idx) * CHUNK +: CHUNK] <= sum;
          carry <= carry_out;
          idx   <= idx + 1'b1;
          // Final slice: sum's MSB is the result's sign bit.
          if (idx == LAST) begin
            borrow_reg   <= ~carry_out;
            overflow_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                            (sum[CHUNK-1] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff     = diff_reg;
  assign borrow   = borrow_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_seq_cla_subtractor.sv
// tb/tb_seq_cla_subtractor.sv - scoreboard bench for seq_cla_subtractor
module tb_seq_cla_subtractor;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  seq_cla_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .minuend   (minuend),
    .subtrahend(subtrahend),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             b;
    logic             o;
    int               lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   errors = 0;
  int   cycle = 0;
  bit   seen = 0;
  bit   rand_ready = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: plain modular and signed arithmetic on the whole word.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t m;
    logic signed [WIDTH:0] sd;
    m.d = a - b;
    m.b = (a < b);
    sd  = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
    m.o = (sd > $signed({2'b00, {(WIDTH-1){1'b1}}})) || (sd < $signed({2'b11, {(WIDTH-1){1'b0}}}));
    m.lat = 0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb[0];
        if (!seen) begin
          chk("latency", 64'(cycle), 64'(mon_e.lat));
          seen = 1;
        end
        chk("diff", diff, mon_e.d);
        chk("borrow", 64'(borrow), 64'(mon_e.b));
        chk("overflow", 64'(overflow), 64'(mon_e.o));
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid   = 1'b1;
    minuend    = a;
    subtrahend = b;
    e = model(a, b);
    e.lat = cycle + 1 + NCH;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    minuend    = {$urandom, $urandom};
    subtrahend = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b, held;
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", diff, 64'd0);
    chk("rst_borrow", 64'(borrow), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    send(64'h3011, 64'h2050);
    send(64'h0, 64'h1);
    send(64'h8000_0000_0000_0000, 64'h1);
    send(64'h0000_0000_0001_0000, 64'h1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();

    // Reset on the second CALC edge must abort silently.
    @(negedge clk);
    in_valid   = 1'b1;
    minuend    = 64'h1234_5678_9ABC_DEF0;
    subtrahend = 64'h0FED_CBA9_8765_4321;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_diff", diff, 64'd0);
    chk("abort_borrow", 64'(borrow), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end

    // Backpressure: hold DONE for five cycles with stray in_valid pulses.
    out_ready = 1'b0;
    a = 64'hDEAD_BEEF_0000_1111;
    b = 64'h0000_0001_FFFF_2222;
    held = a - b;
    send(a, b);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_arrives", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      in_valid   = (i % 2 == 0);
      minuend    = {$urandom, $urandom};
      subtrahend = {$urandom, $urandom};
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_diff_held", diff, held);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = {$urandom, $urandom}; b = a; end
        1: begin a = '0; b = {$urandom, $urandom}; end
        2: begin a = {$urandom, $urandom}; b = '1; end
        3: begin a = {1'b1, 63'($urandom)}; b = {1'b0, 31'($urandom), $urandom}; end
        default: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
      endcase
      send(a, b);
    end
    drain();
    @(negedge clk);
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
